// File: rtl/tero_pkg.sv
// tero_pkg: shared FSM state type, default geometry and response bit indexing for the TERO response builder.
package tero_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_I, CMP_J, DONE} resp_state_t;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_N_BATCH = 10;
  localparam int DEF_N_LANE = 8;
  localparam int DEF_MARGIN = 4;
  localparam int N_BITS = DEF_N_BATCH * DEF_N_LANE;
  localparam int IDX_W = $clog2(N_BITS);
  function automatic int bit_index(input int k, input int l, input int n_batch = DEF_N_BATCH);
    return l * n_batch + k;
  endfunction
endpackage

// File: rtl/tero_cnt_buf.sv
// tero_cnt_buf: register file holding the i-group counts, one sync write port and one combinational read port.
module tero_cnt_buf #(
  parameter int W = 16,
  parameter int D = 80,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/tero_resp_builder.sv
// tero_resp_builder: stores i counts, compares j counts against them and assembles the PUF response.
// Optional reliability mask output enabled by defining TERO_RESP_MARGIN_EN.
module tero_resp_builder
  import tero_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int N_BATCH = DEF_N_BATCH,
  parameter int N_LANE = DEF_N_LANE,
  parameter int MARGIN = DEF_MARGIN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        cnt_valid,
  input  logic [CNT_W-1:0]            cnt_data,
  output logic                        cnt_ready,
  output logic                        busy,
  output logic                        resp_valid,
  output logic [N_BATCH*N_LANE-1:0]   response
`ifdef TERO_RESP_MARGIN_EN
  ,
  output logic [N_BATCH*N_LANE-1:0]   resp_mask
`endif
);
  localparam int BITS = N_BATCH * N_LANE;
  localparam int AW = BITS > 1 ? $clog2(BITS) : 1;
  localparam int KW = N_BATCH > 1 ? $clog2(N_BATCH) : 1;
  localparam int LW = N_LANE > 1 ? $clog2(N_LANE) : 1;
  resp_state_t state;
  logic [KW-1:0] k;
  logic [LW-1:0] l;
  logic [AW-1:0] idx;
  logic [CNT_W-1:0] i_cnt;
  logic xfer, k_last, l_last, restart;
  assign idx = AW'(bit_index(int'(k), int'(l), N_BATCH));
  assign xfer = cnt_valid & cnt_ready;
  assign k_last = k == KW'(N_BATCH - 1);
  assign l_last = l == LW'(N_LANE - 1);
  assign restart = (state == IDLE || state == DONE) && start;
  tero_cnt_buf #(.W(CNT_W), .D(BITS), .AW(AW)) u_buf (
    .clk(clk),
    .we(xfer && state == LOAD_I),
    .waddr(idx),
    .wdata(cnt_data),
    .raddr(idx),
    .rdata(i_cnt)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      k <= '0;
      l <= '0;
      response <= '0;
      cnt_ready <= 1'b0;
      busy <= 1'b0;
      resp_valid <= 1'b0;
    end else if (restart) begin
      state <= LOAD_I;
      k <= '0;
      l <= '0;
      response <= '0;
      cnt_ready <= 1'b1;
      busy <= 1'b1;
      resp_valid <= 1'b0;
    end else if (xfer) begin
      k <= k_last ? '0 : k + 1'b1;
      l <= k_last ? (l_last ? '0 : l + 1'b1) : l;
      if (state == CMP_J) response[idx] <= cnt_data > i_cnt;
      if (k_last && l_last) begin
        state <= state == LOAD_I ? CMP_J : DONE;
        cnt_ready <= state == LOAD_I;
        busy <= state == LOAD_I;
        resp_valid <= state == CMP_J;
      end
    end
`ifdef TERO_RESP_MARGIN_EN
  // Difference carried one bit wider so 0 vs all-ones cannot wrap.
  logic [CNT_W:0] diff;
  assign diff = cnt_data > i_cnt ? {1'b0, cnt_data} - {1'b0, i_cnt} : {1'b0, i_cnt} - {1'b0, cnt_data};
  always_ff @(posedge clk)
    if (reset || restart) resp_mask <= '0;
    else if (xfer && state == CMP_J) resp_mask[idx] <= diff >= (CNT_W + 1)'(MARGIN);
`else
  logic unused_margin;
  assign unused_margin = MARGIN != 0;
`endif
endmodule

// File: tb/tb_tero_resp_builder.sv
// tb_tero_resp_builder: table-driven, scoreboarded bench for tero_resp_builder (10 batches x 8 lanes, 16-bit counts).
module tb_tero_resp_builder;
  localparam int NB = 80;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cnt_valid = 1'b0;
  logic [15:0] cnt_data = '0;
  logic cnt_ready, busy, resp_valid;
  logic [NB-1:0] response;
`ifdef TERO_RESP_MARGIN_EN
  logic [NB-1:0] resp_mask;
`endif
  tero_resp_builder dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cnt_valid(cnt_valid),
    .cnt_data(cnt_data),
    .cnt_ready(cnt_ready),
    .busy(busy),
    .resp_valid(resp_valid),
    .response(response)
`ifdef TERO_RESP_MARGIN_EN
    ,
    .resp_mask(resp_mask)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int mode;
    int gap;
    bit use_model;
    logic [NB-1:0] exp;
  } vec_t;
  typedef struct {
    int idx;
    bit r;
    bit m;
  } sb_t;
  vec_t tv[5];
  sb_t q[$];
  logic [15:0] iv[NB], jv[NB];
  int checks = 0, passed = 0;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] pick();
    int r = $urandom_range(0, 3);
    return r == 0 ? 16'h0000 : r == 1 ? 16'hFFFF : 16'($urandom);
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < NB; i++) begin
      case (mode)
        0: begin iv[i] = 16'd100; jv[i] = 16'd101; end
        1: begin iv[i] = 16'(i); jv[i] = 16'(79 - i); end
        2: begin iv[i] = 16'd500; jv[i] = 16'd500; end
        default: begin iv[i] = pick(); jv[i] = $urandom_range(0, 4) == 0 ? iv[i] : pick(); end
      endcase
    end
  endtask

  function automatic bit rel(input int i);
    int d = int'(jv[i]) - int'(iv[i]);
    return d >= 4 || d <= -4;
  endfunction

  function automatic logic [NB-1:0] model_resp();
    logic [NB-1:0] r = '0;
    for (int i = 0; i < NB; i++) r[i] = jv[i] > iv[i];
    return r;
  endfunction

  function automatic logic [NB-1:0] model_mask();
    logic [NB-1:0] r = '0;
    for (int i = 0; i < NB; i++) r[i] = rel(i);
    return r;
  endfunction

  task automatic send(input logic [15:0] d, input int gap);
    bit ok = 0;
    cnt_valid = 1'b0;
    repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    cnt_valid = 1'b1;
    cnt_data = d;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (cnt_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      checks++;
      $display("FAIL xfer_timeout: cnt_ready stayed 0, expected 1 within 64 cycles");
    end
    cnt_valid = 1'b0;
  endtask

  task automatic run(input int ti, input bit hold_start, input int abort_after);
    logic [NB-1:0] exp;
    int n = 0;
    sb_t e;
    fill(tv[ti].mode);
    exp = tv[ti].use_model ? model_resp() : tv[ti].exp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tv[ti].name, "_busy"}, NB'(busy), NB'(1));
    chk({tv[ti].name, "_ready"}, NB'(cnt_ready), NB'(1));
    chk({tv[ti].name, "_restart_valid"}, NB'(resp_valid), NB'(0));
    chk({tv[ti].name, "_restart_resp"}, response, '0);
    for (int g = 0; g < 2; g++)
      for (int l = 0; l < 8; l++)
        for (int k = 0; k < 10; k++) begin
          int idx = l * 10 + k;
          if (g == 1 && n == abort_after) begin start = 1'b0; return; end
          if (g == 1 && hold_start) start = 1'b1;
          if (g == 1 && idx == NB - 1) chk({tv[ti].name, "_valid_early"}, NB'(resp_valid), NB'(0));
          send(g ? jv[idx] : iv[idx], tv[ti].gap);
          if (g == 1) begin
            q.push_back('{idx, jv[idx] > iv[idx], rel(idx)});
            e = q.pop_front();
            chk($sformatf("%s_bit%0d", tv[ti].name, e.idx), NB'(response[e.idx]), NB'(e.r));
`ifdef TERO_RESP_MARGIN_EN
            chk($sformatf("%s_mask%0d", tv[ti].name, e.idx), NB'(resp_mask[e.idx]), NB'(e.m));
`endif
            n++;
          end
        end
    start = 1'b0;
    chk({tv[ti].name, "_latency"}, NB'(resp_valid), NB'(1));
    chk({tv[ti].name, "_response"}, response, exp);
    chk({tv[ti].name, "_done_ready"}, NB'(cnt_ready), NB'(0));
    chk({tv[ti].name, "_done_busy"}, NB'(busy), NB'(0));
`ifdef TERO_RESP_MARGIN_EN
    chk({tv[ti].name, "_mask"}, resp_mask, model_mask());
`endif
  endtask

  initial begin
    tv[0] = '{"all_gt", 0, 0, 1'b0, {NB{1'b1}}};
    tv[1] = '{"order", 1, 0, 1'b0, 80'h0000000000FFFFFFFFFF};
    tv[2] = '{"ties", 2, 0, 1'b0, '0};
    tv[3] = '{"rand_gap", 3, 3, 1'b1, '0};
    tv[4] = '{"rand", 3, 0, 1'b1, '0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", NB'(cnt_ready), NB'(0));
    chk("rst_busy", NB'(busy), NB'(0));
    chk("rst_valid", NB'(resp_valid), NB'(0));
    chk("rst_resp", response, '0);
    reset = 1'b0;
    cnt_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_ready", NB'(cnt_ready), NB'(0));
    chk("idle_busy", NB'(busy), NB'(0));
    cnt_valid = 1'b0;
    run(0, 1'b0, -1);
    cnt_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("done_ready_hold", NB'(cnt_ready), NB'(0));
    chk("done_valid_hold", NB'(resp_valid), NB'(1));
    chk("done_resp_hold", response, {NB{1'b1}});
    cnt_valid = 1'b0;
    run(1, 1'b0, -1);
    run(2, 1'b0, -1);
    run(3, 1'b0, -1);
    run(4, 1'b0, 50);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", NB'(busy), NB'(0));
    chk("mid_rst_resp", response, '0);
    chk("mid_rst_valid", NB'(resp_valid), NB'(0));
    chk("mid_rst_ready", NB'(cnt_ready), NB'(0));
    run(4, 1'b0, -1);
    run(1, 1'b1, -1);
    run(3, 1'b1, -1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/tero_resp_builder.md
Name: tero_resp_builder

Overview:
- Consumer end of the TERO evaluation sequence. Receives one measured count per TERO in the order the frequency sequencer issues indices.
- Order: all N_BATCH×N_LANE "i" counts first, then the same number of "j" counts. In each group, lane l is outer and batch k is inner (k fastest).
- Stores the i-group counts. Compares each arriving j count against the stored i count at the same (k,l).
- Assembles the N_BATCH×N_LANE-bit PUF response and presents it to the readout logic.

Parameters:
- CNT_W, 16, width of one TERO oscillation count.
- N_BATCH, 10, number of batches k per group.
- N_LANE, 8, number of lanes l per batch.
- MARGIN, 4, minimum |j−i| for a bit to be reliable. Used only with TERO_RESP_MARGIN_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new response.
- cnt_valid  in  1  cnt_data holds a valid count.
- cnt_data  in  CNT_W  TERO count, unsigned.
- cnt_ready  out  1  block accepts a count this cycle.
- busy  out  1  collection in progress.
- resp_valid  out  1  response complete and stable.
- response  out  N_BATCH*N_LANE  response bits; bit index = l*N_BATCH + k.
- resp_mask  out  N_BATCH*N_LANE  reliability mask. Present only with TERO_RESP_MARGIN_EN.

Behaviour:
- Reset state: IDLE. Outputs: cnt_ready=0, busy=0, resp_valid=0, response=0, resp_mask=0. Internal k, l, and buffer write pointer = 0. Buffer contents are don't-care.
- A transfer occurs on a clk edge where cnt_valid & cnt_ready are both 1. cnt_data is sampled only on a transfer.
- FSM states and transitions:
  - IDLE: on start → LOAD_I. Clear k, l and response; clear resp_mask (when present).
  - LOAD_I: cnt_ready=1, busy=1. Each transfer writes buf[l*N_BATCH+k] and advances k. When k reaches N_BATCH-1, k wraps to 0 and l increments. Transfer at (k=N_BATCH-1, l=N_LANE-1) → CMP_J with k=l=0.
  - CMP_J: cnt_ready=1, busy=1. Each transfer compares cnt_data (j) with buf[idx] (i), idx=l*N_BATCH+k. On the same edge, response[idx] <= (j > i). Ties give 0. Counters advance as in LOAD_I. Last transfer → DONE.
  - DONE: cnt_ready=0, busy=0, resp_valid=1. response is held. On start → LOAD_I, with resp_valid=0 on the next cycle and response cleared.
- Latency: resp_valid rises on the cycle after the clock edge that accepted the final j count.
- start asserted in LOAD_I or CMP_J is ignored.
- cnt_valid asserted in IDLE or DONE: no transfer occurs and the data is dropped.
- Compare arithmetic:
  - Unsigned, CNT_W bits, no saturation.
  - Difference is computed CNT_W+1 bits wide to avoid wrap.
  - Counts of 0 and 2^CNT_W−1 are legal.
- Reset mid-operation: immediately returns to IDLE with all outputs at reset values. A partially built response is discarded.
- Buffer read path is combinational from registers. The block supports back-to-back transfers every cycle and arbitrary cnt_valid gaps.

Optional Feature:
- Macro TERO_RESP_MARGIN_EN.
- Defined:
  - resp_mask port exists.
  - On each j transfer, resp_mask[idx] <= (|j−i| >= MARGIN).
  - response is unchanged by the mask.
- Undefined:
  - resp_mask port and margin logic are absent.
  - MARGIN is unused.

Decomposition:
- Package tero_pkg:
  - typedef enum resp_state_t {IDLE, LOAD_I, CMP_J, DONE}.
  - Localparams N_BITS = N_BATCH*N_LANE and IDX_W = $clog2(N_BITS).
  - Function bit_index(k, l).
- One sub-module, tero_cnt_buf:
  - N_BITS × CNT_W register file.
  - One synchronous write port and one combinational read port.
  - Write and read addresses are separate.

Test Plan:
- i counts all 100, j counts all 101, no gaps → response all ones; resp_valid exactly 1 cycle after the 160th transfer.
- i = idx, j = 79−idx → response bit set iff idx < 40. Checks bit ordering l*10+k.
- All i = j = 500 → response all zeros (ties give 0). With TERO_RESP_MARGIN_EN, resp_mask is all zeros.
- Random cnt_valid gaps and values 0/65535 → matches the reference model; cnt_ready low in IDLE and DONE.
- reset pulsed after the 50th j transfer → next cycle is IDLE with response=0 and busy=0. A fresh start then completes a correct response.
- start held during CMP_J is ignored. start in DONE drops resp_valid, clears response, and reloads.
